tb_scoreboard: RTL

In-order expected/actual scoreboard for unit benches. Bench stimulus pushes expected values into an internal FIFO. Observed DUT values are compared against the FIFO head in arrival order. The block produces the 32-bit `error` code that drives the bench's error reporter (0 = no error, nonzero = failing check index), plus a final pass/fail verdict when the bench signals end of test.

---
 rtl/tb_scoreboard_if.sv | 32 +++
 rtl/tb_scoreboard.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tb_scoreboard_if.sv
// tb_scoreboard_if: bundles the expected/actual streams, the end-of-test
// strobe and the verdict/status outputs of the in-order scoreboard.
// master = bench side, slave = scoreboard side.
interface tb_scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             exp_ready;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;
  logic             done;
  logic [31:0]      error;
  logic [1:0]       err_kind;
  logic             pass;
  logic             finished;
  logic [31:0]      match_count;
  logic [PW-1:0]    pending;

  modport master (
    output exp_valid, exp_data, act_valid, act_data, done,
    input  exp_ready, error, err_kind, pass, finished, match_count, pending
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data, done,
    output exp_ready, error, err_kind, pass, finished, match_count, pending
  );
endinterface

// File: rtl/tb_scoreboard.sv
// tb_scoreboard: in-order expected/actual scoreboard. Expected values queue
// up in a FIFO; each observed value is compared against the FIFO head. The
// first failure latches an error code and freezes everything until reset.
module tb_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  tb_scoreboard_if.slave   sb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [31:0] IDX_MAX  = 32'hFFFF_FFFE;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t           state_reg, state_next;
  logic [AW:0]      wptr_reg, wptr_next;
  logic [AW:0]      rptr_reg, rptr_next;
  logic [31:0]      idx_reg, idx_next;
  logic [31:0]      error_reg, error_next;
  logic [31:0]      match_reg, match_next;
  logic [1:0]       kind_reg, kind_next;
  logic             cmp_fail;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      occ;
  logic             empty;
  logic             full;
  logic             ready;
  logic             push;
  logic [WIDTH-1:0] head;

  // Occupancy comes straight from the wrap-bit pointers; ready depends only
  // on registered state so it never loops back through the bench's valids.
  assign occ   = wptr_reg - rptr_reg;
  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);
  assign ready = (state_reg == ST_RUN) && !full;
  assign push  = sb.exp_valid && ready;
  assign head  = mem[rptr_reg[AW-1:0]];

  // Expected-value storage; contents are not reset, the pointers define
  // what is valid, so a reset discards everything by clearing them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_reg[AW-1:0]] <= sb.exp_data;
    end
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      idx_reg   <= '0;
      error_reg <= '0;
      match_reg <= '0;
      kind_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      idx_reg   <= idx_next;
      error_reg <= error_next;
      match_reg <= match_next;
      kind_reg  <= kind_next;
    end
  end

  // Next-state: push, compare against head (no bypass from a same-cycle
  // push), then resolve done using the post-update occupancy.
  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    idx_next   = idx_reg;
    error_next = error_reg;
    match_next = match_reg;
    kind_next  = kind_reg;
    cmp_fail   = 1'b0;

    if (state_reg == ST_RUN) begin
      if (push) begin
        wptr_next = wptr_reg + 1'b1;
      end

      if (sb.act_valid) begin
        if (idx_reg != IDX_MAX) begin
          idx_next = idx_reg + 32'd1;
        end
        if (!empty) begin
          rptr_next = rptr_reg + 1'b1;
          if (head == sb.act_data) begin
            if (match_reg != ALL_ONES) begin
              match_next = match_reg + 32'd1;
            end
          end else begin
            cmp_fail   = 1'b1;
            error_next = idx_reg + 32'd1;
            kind_next  = 2'd1;
          end
        end else begin
          cmp_fail   = 1'b1;
          error_next = idx_reg + 32'd1;
          kind_next  = 2'd2;
        end
      end

      if (cmp_fail) begin
        state_next = ST_FAIL;
      end else if (sb.done) begin
        if (wptr_next == rptr_next) begin
          state_next = ST_PASS;
        end else begin
          state_next = ST_FAIL;
          error_next = ALL_ONES;
          kind_next  = 2'd3;
        end
      end
    end
  end

  assign sb.exp_ready   = ready;
  assign sb.error       = error_reg;
  assign sb.err_kind    = kind_reg;
  assign sb.pass        = (state_reg == ST_PASS);
  assign sb.finished    = (state_reg != ST_RUN);
  assign sb.match_count = match_reg;
  assign sb.pending     = occ;
endmodule
